window_linebuf_gen: RTL and testbench
=====================================

WINDOW_LINEBUF_GEN -- requirements
Module: window_linebuf_gen

Interface
REQ-001 SHALL have parameter BITSIZE, default 18, signed pixel width.
REQ-002 SHALL have parameter CHANNELS, default 3, number of parallel pixel channels.
REQ-003 SHALL have parameter IMG_W, default 224, pixels per row (min 3).
REQ-004 SHALL have parameter IMG_H, default 224, rows per frame (min 3).
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port in_pixel  in  CHANNELS*BITSIZE  one pixel per channel; channel k at bits [k*BITSIZE +: BITSIZE].
REQ-008 SHALL have port in_valid  in  1  in_pixel is valid.
REQ-009 SHALL have port in_ready  out  1  block accepts in_pixel this cycle.
REQ-010 SHALL have port stride2  in  1  0 = stride 1, 1 = stride 2.
REQ-011 SHALL have port out_window  out  CHANNELS*9*BITSIZE  3x3 window per channel.
REQ-012 SHALL have port out_valid  out  1  out_window holds a valid window.
REQ-013 SHALL have port out_ready  in  1  consumer accepts out_window.
REQ-014 SHALL have port frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-015 SHALL accept a pixel only when in_valid && in_ready; pixels arrive in raster order, row 0 col 0 first.
REQ-016 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1); col wraps to 0 and row increments at col=IMG_W-1; at row=IMG_H-1, col=IMG_W-1 both return to 0.
REQ-017 SHALL sample stride2 only on acceptance of pixel (0,0) and hold it for the whole frame.
REQ-018 SHALL keep two IMG_W-deep line buffers per channel holding the previous two rows, written on every accepted pixel.
REQ-019 SHALL produce a window on acceptance of pixel (r,c) only if r>=2, c>=2, and, in stride-2 mode, (r-2) and (c-2) are both even; no padding windows.
REQ-020 SHALL set window element (i,j), i=row 0..2 top-down, j=col 0..2 left-right, to pixel (r-2+i, c-2+j), placed at bits [k*9*BITSIZE + (i*3+j)*BITSIZE +: BITSIZE] for channel k.
REQ-021 SHALL register the window: out_valid and out_window update on the clock edge that accepts the completing pixel (latency 1 cycle).
REQ-022 SHALL hold out_window and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL drive in_ready = !out_valid || out_ready (combinational; one-deep output stage, no pixel lost).
REQ-024 SHALL, when out_ready and a new window are accepted in the same cycle, replace the output with the new window and keep out_valid=1.
REQ-025 SHALL clear out_valid on out_ready when no new window is produced that cycle.
REQ-026 SHALL never mix rows across a row wrap; window columns c-2..c lie in a single row span.
REQ-027 SHALL pass values unmodified; no arithmetic, sign preserved.
REQ-028 SHALL assert frame_done one cycle after acceptance of pixel (IMG_H-1, IMG_W-1).

Reset
REQ-029 SHALL on rst clear col, row, out_valid, frame_done, and the latched stride to 0; out_window SHALL reset to 0.
REQ-030 SHALL not require line-buffer memory reset; row>=2 gating ensures stale contents never reach out_window.
REQ-031 SHALL, when rst asserts mid-frame, abandon the frame; the next accepted pixel is (0,0).

Structure
REQ-032 SHALL place window size constant (3), window-index helper, and default BITSIZE/CHANNELS in shared package cnn_pkg.
REQ-033 SHALL instantiate sub-module line_fifo (one per channel, IMG_W deep, 2 taps) for the line buffers.

Verification (IMG_W=8, IMG_H=6, CHANNELS=3, pixel ch k = 100*k + 8*row + col)
REQ-034 SHALL check stride 1, out_ready=1, in_valid=1: 24 windows; first at pixel (2,2), ch0 element (0,0)=0, (2,2)=18; frame_done once.
REQ-035 SHALL check stride2=1: exactly 6 windows, anchors (0,0),(0,2),(0,4),(2,0),(2,2),(2,4) as top-left; ch2 first window element (1,1)=209.
REQ-036 SHALL check out_ready low 5 cycles with out_valid=1: in_ready=0, window stable, no window dropped, total still 24.
REQ-037 SHALL check rst asserted at pixel (3,4): out_valid=0 next cycle; a fresh frame then yields 24 correct windows, none from stale rows.
REQ-038 SHALL check random in_valid gaps: window sequence identical to gap-free run.

Source files
------------

// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants and helpers for the sliding-window line-buffer blocks.
//   WIN          : window edge length (3x3 windows)
//   WIN_ELEMS    : elements per window per channel
//   DEF_BITSIZE  : default signed pixel width
//   DEF_CHANNELS : default number of parallel pixel channels
//   win_idx()    : row-major element index inside one channel's window
//   win_lsb()    : bit offset of element (i,j) of channel k in a packed window
// -----------------------------------------------------------------------------
package cnn_pkg;

   localparam int WIN          = 3;
   localparam int WIN_ELEMS    = WIN * WIN;
   localparam int DEF_BITSIZE  = 18;
   localparam int DEF_CHANNELS = 3;

   function automatic int win_idx(input int i, input int j);
      return i * WIN + j;
   endfunction

   function automatic int win_lsb(input int k, input int i, input int j, input int bitsize);
      return (k * WIN_ELEMS + win_idx(i, j)) * bitsize;
   endfunction

endpackage

// File: rtl/line_fifo.sv
// -----------------------------------------------------------------------------
// line_fifo
// Two cascaded row memories for one channel. Row memory 1 holds the previous
// row, row memory 2 the row before it. Both are read through a registered
// port so they map onto block RAM.
//   clk       : clock
//   i_wr_en   : write the current pixel (and shift the column down one row)
//   i_wr_addr : column being written
//   i_rd_addr : column to present on the taps after the next edge
//   i_data    : incoming pixel
//   o_tap1    : pixel one row above i_rd_addr's column (registered)
//   o_tap2    : pixel two rows above i_rd_addr's column (registered)
// -----------------------------------------------------------------------------
module line_fifo
   import cnn_pkg::*;
#(
   parameter int BITSIZE = DEF_BITSIZE,
   parameter int DEPTH   = 224,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               i_wr_en,
   input  logic [AW-1:0]      i_wr_addr,
   input  logic [AW-1:0]      i_rd_addr,
   input  logic [BITSIZE-1:0] i_data,
   output logic [BITSIZE-1:0] o_tap1,
   output logic [BITSIZE-1:0] o_tap2
);

   logic [BITSIZE-1:0] r_line1 [DEPTH];
   logic [BITSIZE-1:0] r_line2 [DEPTH];
   logic [BITSIZE-1:0] r_tap1;
   logic [BITSIZE-1:0] r_tap2;

   // The owner keeps i_rd_addr pointing at the column of the next write, so
   // r_tap1 already holds r_line1[i_wr_addr] when that write happens; it is
   // the value that moves down into row memory 2. Read and write addresses
   // never coincide on a write cycle, so no read-during-write case arises.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_line1[i_wr_addr] <= i_data;
         r_line2[i_wr_addr] <= r_tap1;
      end
      r_tap1 <= r_line1[i_rd_addr];
      r_tap2 <= r_line2[i_rd_addr];
   end

   assign o_tap1 = r_tap1;
   assign o_tap2 = r_tap2;

endmodule

// File: rtl/window_linebuf_gen.sv
// -----------------------------------------------------------------------------
// window_linebuf_gen
// Builds 3x3 windows from a raster-order pixel stream, CHANNELS in parallel,
// with optional stride 2, behind a one-deep valid/ready output register.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_pixel   : one pixel per channel, channel k at [k*BITSIZE +: BITSIZE]
//   in_valid   : in_pixel valid
//   in_ready   : pixel accepted this cycle when in_valid is also high
//   stride2    : stride select, latched with pixel (0,0)
//   out_window : 3x3 window per channel, element (i,j) of channel k at
//                [k*9*BITSIZE + (i*3+j)*BITSIZE +: BITSIZE]
//   out_valid  : out_window valid
//   out_ready  : consumer takes out_window
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module window_linebuf_gen
   import cnn_pkg::*;
#(
   parameter int BITSIZE  = DEF_BITSIZE,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int IMG_W    = 224,
   parameter int IMG_H    = 224
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [CHANNELS*BITSIZE-1:0]         in_pixel,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                stride2,
   output logic [CHANNELS*WIN_ELEMS*BITSIZE-1:0] out_window,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int OW = CHANNELS * WIN_ELEMS * BITSIZE;

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          r_stride;
   logic          r_out_valid;
   logic          r_frame_done;
   logic [OW-1:0] r_out_window;

   logic [CW-1:0] w_col_next;
   logic [RW-1:0] w_row_next;
   logic [CW-1:0] w_rd_addr;
   logic          w_accept;
   logic          w_first;
   logic          w_col_last;
   logic          w_row_last;
   logic          w_stride;
   logic          w_produce;
   logic [OW-1:0] w_win_new;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready && !rst;
   assign w_first    = (r_col == '0) && (r_row == '0);
   assign w_col_last = (r_col == CW'(IMG_W - 1));
   assign w_row_last = (r_row == RW'(IMG_H - 1));

   // Stride is taken live on pixel (0,0) and from the latch afterwards, so
   // the very first pixel of a frame already obeys the new setting.
   assign w_stride  = w_first ? stride2 : r_stride;
   assign w_produce = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                      (!w_stride || (!r_row[0] && !r_col[0]));

   always_comb begin
      w_col_next = w_col_last ? '0 : r_col + CW'(1);
      w_row_next = r_row;
      if (w_col_last) begin
         w_row_next = w_row_last ? '0 : r_row + RW'(1);
      end
      // Keep the line-memory read port aimed at the column of the next pixel.
      w_rd_addr = r_col;
      if (rst) begin
         w_rd_addr = '0;
      end else if (w_accept) begin
         w_rd_addr = w_col_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_stride     <= 1'b0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_out_window <= '0;
      end else begin
         r_frame_done <= w_accept && w_col_last && w_row_last;
         if (w_accept) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
            if (w_first) begin
               r_stride <= stride2;
            end
         end
         if (w_produce) begin
            r_out_valid  <= 1'b1;
            r_out_window <= w_win_new;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   genvar gi, gr;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [BITSIZE-1:0] w_px;
         logic [BITSIZE-1:0] w_tap1;
         logic [BITSIZE-1:0] w_tap2;
         logic [BITSIZE-1:0] w_newcol [WIN];
         // Columns c-2 and c-1 of the three window rows. They shift on every
         // accepted pixel, so once c>=2 both come from the current row span.
         logic [BITSIZE-1:0] r_hist1 [WIN];
         logic [BITSIZE-1:0] r_hist2 [WIN];

         assign w_px = in_pixel[gi*BITSIZE +: BITSIZE];

         line_fifo #(
            .BITSIZE (BITSIZE),
            .DEPTH   (IMG_W),
            .AW      (CW)
         ) u_line_fifo (
            .clk       (clk),
            .i_wr_en   (w_accept),
            .i_wr_addr (r_col),
            .i_rd_addr (w_rd_addr),
            .i_data    (w_px),
            .o_tap1    (w_tap1),
            .o_tap2    (w_tap2)
         );

         assign w_newcol[0] = w_tap2;
         assign w_newcol[1] = w_tap1;
         assign w_newcol[2] = w_px;

         always_ff @(posedge clk) begin
            if (w_accept) begin
               for (int i = 0; i < WIN; i++) begin
                  r_hist1[i] <= r_hist2[i];
                  r_hist2[i] <= w_newcol[i];
               end
            end
         end

         for (gr = 0; gr < WIN; gr++) begin : g_row
            assign w_win_new[win_lsb(gi, gr, 0, BITSIZE) +: BITSIZE] = r_hist1[gr];
            assign w_win_new[win_lsb(gi, gr, 1, BITSIZE) +: BITSIZE] = r_hist2[gr];
            assign w_win_new[win_lsb(gi, gr, 2, BITSIZE) +: BITSIZE] = w_newcol[gr];
         end
      end
   endgenerate

   assign out_window = r_out_window;
   assign out_valid  = r_out_valid;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_linebuf_gen.sv
// -----------------------------------------------------------------------------
// tb_window_linebuf_gen
// Drives IMG_W=8, IMG_H=6, CHANNELS=3 frames with pixel value
// 100*k + 8*row + col and checks every delivered window against windows
// computed directly from that formula.
// -----------------------------------------------------------------------------
module tb_window_linebuf_gen;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int C  = 3;
   localparam int B  = 18;
   localparam int WB = C * 9 * B;

   logic          clk = 1'b0;
   logic          rst;
   logic [C*B-1:0] in_pixel;
   logic          in_valid;
   logic          in_ready;
   logic          stride2;
   logic [WB-1:0] out_window;
   logic          out_valid;
   logic          out_ready;
   logic          frame_done;

   window_linebuf_gen #(
      .BITSIZE  (B),
      .CHANNELS (C),
      .IMG_W    (W),
      .IMG_H    (H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_pixel   (in_pixel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .stride2    (stride2),
      .out_window (out_window),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // model / monitor state
   int            m_r = 0, m_c = 0;
   bit            m_stride = 0;
   logic [WB-1:0] exp_q[$];
   logic [WB-1:0] got_q[$];
   logic [WB-1:0] ref_q[$];
   int            win_count = 0, fd_count = 0, stall_cycles = 0;
   bit            prev_acc_last = 0, prev_rst = 0, prev_stall = 0;
   logic [WB-1:0] prev_win;
   bit            stall_arm = 0;

   function automatic logic [B-1:0] pix(input int k, input int r, input int c);
      return B'(100 * k + 8 * r + c);
   endfunction

   function automatic logic [C*B-1:0] pix_word(input int r, input int c);
      logic [C*B-1:0] w;
      for (int k = 0; k < C; k++) w[k*B +: B] = pix(k, r, c);
      return w;
   endfunction

   function automatic logic [WB-1:0] exp_win(input int r, input int c);
      logic [WB-1:0] w;
      for (int k = 0; k < C; k++)
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               w[(k*9 + i*3 + j)*B +: B] = pix(k, r - 2 + i, c - 2 + j);
      return w;
   endfunction

   function automatic logic [B-1:0] elem(input logic [WB-1:0] w, input int k, input int i, input int j);
      return w[(k*9 + i*3 + j)*B +: B];
   endfunction

   task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   // Compare process: runs on the falling edge, between input changes.
   always @(negedge clk) begin
      if (rst) begin
         m_r = 0; m_c = 0; m_stride = 0;
         exp_q.delete();
         prev_rst = 1; prev_acc_last = 0; prev_stall = 0;
      end else begin
         if (prev_rst) chk("valid_after_rst", WB'(out_valid), WB'(0));
         chk("frame_done", WB'(frame_done), WB'(prev_acc_last));
         chk("in_ready", WB'(in_ready), WB'(!out_valid || out_ready));
         if (prev_stall) begin
            chk("stall_valid_held", WB'(out_valid), WB'(1));
            chk("stall_window_held", out_window, prev_win);
         end
         if (out_valid && !out_ready) stall_cycles++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_window", WB'(1), WB'(0));
            end else begin
               chk("window", out_window, exp_q.pop_front());
            end
            got_q.push_back(out_window);
            win_count++;
         end
         if (in_valid && in_ready) begin
            if (m_r == 0 && m_c == 0) m_stride = stride2;
            if (m_r >= 2 && m_c >= 2 && (!m_stride || (m_r % 2 == 0 && m_c % 2 == 0)))
               exp_q.push_back(exp_win(m_r, m_c));
            prev_acc_last = (m_r == H - 1 && m_c == W - 1);
            if (m_c == W - 1) begin
               m_c = 0;
               m_r = (m_r == H - 1) ? 0 : m_r + 1;
            end else begin
               m_c++;
            end
         end else begin
            prev_acc_last = 0;
         end
         if (frame_done) fd_count++;
         prev_stall = out_valid && !out_ready;
         prev_win   = out_window;
         prev_rst   = 0;
      end
   end

   // Consumer back-pressure: once armed, holds out_ready low for 5 cycles.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         if (stall_arm && out_valid && win_count >= 5) begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #2;
            out_ready = 1'b1;
            stall_arm = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   // Present one frame; stop_at >= 0 asserts rst while that pixel is offered.
   task automatic drive_frame(input bit s2, input bit gaps, input int stop_at);
      bit acc;
      int t;
      for (int idx = 0; idx < W * H; idx++) begin
         in_pixel = pix_word(idx / W, idx % W);
         // Only the setting seen with pixel (0,0) may take effect.
         stride2 = (idx == 0) ? s2 : !s2;
         if (idx == stop_at) begin
            in_valid = 1'b1;
            rst = 1'b1;
            step();
            rst = 1'b0;
            in_valid = 1'b0;
            return;
         end
         if (gaps) begin
            int ng = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (ng) step();
         end
         in_valid = 1'b1;
         t = 0;
         do begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            t++;
         end while (!acc && t < 200);
         if (!acc) chk("accept_timeout", WB'(0), WB'(1));
      end
      in_valid = 1'b0;
      repeat (10) step();
      chk("queue_drained", WB'(exp_q.size()), WB'(0));
   endtask

   task automatic new_frame();
      win_count = 0; fd_count = 0; stall_cycles = 0;
      got_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; stride2 = 1'b0; in_pixel = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", WB'(out_valid), WB'(0));
      chk("reset_out_window", out_window, WB'(0));
      chk("reset_frame_done", WB'(frame_done), WB'(0));
      chk("reset_in_ready", WB'(in_ready), WB'(1));
      step();

      // stride 1, no gaps
      new_frame();
      drive_frame(1'b0, 1'b0, -1);
      chk("s1_count", WB'(win_count), WB'(24));
      chk("s1_frame_done_count", WB'(fd_count), WB'(1));
      chk("s1_first_ch0_00", WB'(elem(got_q[0], 0, 0, 0)), WB'(0));
      chk("s1_first_ch0_22", WB'(elem(got_q[0], 0, 2, 2)), WB'(18));
      chk("s1_last_ch1_22", WB'(elem(got_q[23], 1, 2, 2)), WB'(147));
      ref_q = got_q;

      // stride 2
      new_frame();
      drive_frame(1'b1, 1'b0, -1);
      chk("s2_count", WB'(win_count), WB'(6));
      chk("s2_first_ch2_11", WB'(elem(got_q[0], 2, 1, 1)), WB'(209));
      chk("s2_anchor1_ch0_00", WB'(elem(got_q[1], 0, 0, 0)), WB'(2));
      chk("s2_anchor3_ch0_00", WB'(elem(got_q[3], 0, 0, 0)), WB'(16));
      chk("s2_anchor5_ch0_00", WB'(elem(got_q[5], 0, 0, 0)), WB'(20));

      // back-pressure for 5 cycles mid-frame
      new_frame();
      stall_arm = 1;
      drive_frame(1'b0, 1'b0, -1);
      chk("stall_count", WB'(win_count), WB'(24));
      chk("stall_cycles", WB'(stall_cycles), WB'(5));

      // reset while pixel (3,4) is offered, then a clean frame
      new_frame();
      drive_frame(1'b0, 1'b0, 3 * W + 4);
      step();
      new_frame();
      drive_frame(1'b0, 1'b0, -1);
      chk("post_rst_count", WB'(win_count), WB'(24));
      for (int i = 0; i < 24 && i < got_q.size(); i++)
         chk("post_rst_vs_ref", got_q[i], ref_q[i]);

      // random input gaps must not change the window sequence
      new_frame();
      drive_frame(1'b0, 1'b1, -1);
      chk("gap_count", WB'(win_count), WB'(24));
      for (int i = 0; i < 24 && i < got_q.size(); i++)
         chk("gap_vs_ref", got_q[i], ref_q[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
